bsg_wormhole_link_monitor: RTL



---
 rtl/bsg_wormhole_link_monitor_pkg.sv | 28 ++
 rtl/bsg_two_fifo.sv | 44 ++++
 rtl/bsg_wormhole_link_monitor.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/bsg_wormhole_link_monitor_pkg.sv
// Shared types and constants for the wormhole link monitor.
// Header field placement, error bit indices and LFSR taps.
package bsg_wormhole_link_monitor_pkg;

  typedef enum logic {
    HDR  = 1'b0,
    BODY = 1'b1
  } state_e;

  localparam int cord_lsb_lp = 0;

  function automatic int len_lsb(input int cord_w);
    return cord_w;
  endfunction

  function automatic int cid_lsb(input int cord_w, input int len_w);
    return cord_w + len_w;
  endfunction

  localparam int err_cord_bit_lp = 0;
  localparam int err_cid_bit_lp  = 1;
  localparam int err_wd_bit_lp   = 2;
  localparam int err_width_lp    = 3;

  // Fibonacci taps 16,14,13,11 as a mask on lfsr[15:0]
  localparam logic [15:0] lfsr_taps_lp = 16'hB400;

endpackage

// File: rtl/bsg_two_fifo.sv
// Two-entry FIFO, registered output, no pass-through.
// Active-high asynchronous reset clears every flop.
module bsg_two_fifo #(
  parameter int width_p = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enq_v,
  input  logic [width_p-1:0] enq_data,
  output logic               enq_ready,
  output logic               deq_v,
  output logic [width_p-1:0] deq_data,
  input  logic               deq_yumi
);

  logic [width_p-1:0] mem [2];
  logic               wptr;
  logic               rptr;
  logic [1:0]         cnt;
  logic               enq;

  assign enq_ready = (cnt != 2'd2);
  assign deq_v     = (cnt != 2'd0);
  assign deq_data  = mem[rptr];
  assign enq       = enq_v & enq_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wptr   <= 1'b0;
      rptr   <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (enq) begin
        mem[wptr] <= enq_data;
        wptr      <= ~wptr;
      end
      if (deq_yumi) rptr <= ~rptr;
      cnt <= cnt + 2'(enq) - 2'(deq_yumi);
    end
  end

endmodule

// File: rtl/bsg_wormhole_link_monitor.sv
// Inline wormhole link stage: buffering, stall injection,
// packet framing, sticky error flags and traffic counters.
module bsg_wormhole_link_monitor
  import bsg_wormhole_link_monitor_pkg::*;
#(
  parameter int          flit_width_p      = 16,
  parameter int          cord_width_p      = 5,
  parameter int          len_width_p       = 4,
  parameter int          cid_width_p       = 2,
  parameter int          num_cid_p         = 1 << cid_width_p,
  parameter int          watchdog_cycles_p = 1024,
  parameter logic [15:0] lfsr_seed_p       = 16'hACE1
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic [cord_width_p-1:0] expected_cord_i,
  input  logic                    stall_en_i,
  input  logic [3:0]              stall_thresh_i,
  input  logic                    v_i,
  input  logic [flit_width_p-1:0] data_i,
  output logic                    ready_and_o,
  output logic                    v_o,
  output logic [flit_width_p-1:0] data_o,
  input  logic                    ready_and_i,
  output logic                    error_o,
  output logic [2:0]              err_code_o,
  output logic [31:0]             flit_count_o,
  output logic [31:0]             packet_count_o
);

  localparam int len_lsb_lp  = len_lsb(cord_width_p);
  localparam int cid_lsb_lp  = cid_lsb(cord_width_p, len_width_p);
  localparam int wd_width_lp = $clog2(watchdog_cycles_p + 1);

  logic                    fifo_reset;
  logic                    fifo_ready;
  logic                    fifo_v;
  logic [flit_width_p-1:0] fifo_data;
  logic                    stall;
  logic                    hs;

  assign fifo_reset = ~reset_n_i;

  bsg_two_fifo #(.width_p(flit_width_p)) fifo (
    .clk      (clk_i),
    .reset    (fifo_reset),
    .enq_v    (v_i),
    .enq_data (data_i),
    .enq_ready(fifo_ready),
    .deq_v    (fifo_v),
    .deq_data (fifo_data),
    .deq_yumi (hs)
  );

  // FIFO clears to empty in reset, so gate ready explicitly
  assign ready_and_o = reset_n_i & fifo_ready;

  logic [15:0] lfsr;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) lfsr <= lfsr_seed_p;
    else            lfsr <= {lfsr[14:0], ^(lfsr & lfsr_taps_lp)};
  end

  assign stall  = stall_en_i & (lfsr[3:0] < stall_thresh_i);
  assign v_o    = fifo_v & ~stall;
  assign data_o = fifo_data;
  assign hs     = v_o & ready_and_i;

  logic [cord_width_p-1:0] hdr_cord;
  logic [len_width_p-1:0]  hdr_len;
  logic [cid_width_p-1:0]  hdr_cid;

  assign hdr_cord = fifo_data[cord_lsb_lp +: cord_width_p];
  assign hdr_len  = fifo_data[len_lsb_lp +: len_width_p];
  assign hdr_cid  = fifo_data[cid_lsb_lp +: cid_width_p];

  state_e                 state, state_n;
  logic [len_width_p-1:0] rem, rem_n;
  logic                   pkt_done;
  logic                   hdr_hs;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state <= HDR;
      rem   <= '0;
    end else begin
      state <= state_n;
      rem   <= rem_n;
    end
  end

  always_comb begin
    state_n  = state;
    rem_n    = rem;
    pkt_done = 1'b0;
    hdr_hs   = 1'b0;
    unique case (state)
      HDR: if (hs) begin
        hdr_hs = 1'b1;
        rem_n  = hdr_len;
        if (hdr_len == '0) pkt_done = 1'b1;
        else               state_n  = BODY;
      end
      BODY: if (hs) begin
        rem_n = rem - 1'b1;
        if (rem == len_width_p'(1)) begin
          pkt_done = 1'b1;
          state_n  = HDR;
        end
      end
      default: state_n = HDR;
    endcase
  end

  logic [wd_width_lp-1:0] wd;
  logic                   wd_inc;
  logic                   wd_hit;
  logic                   wd_trip;

  assign wd_inc  = fifo_v & ~hs;
  assign wd_hit  = (wd == wd_width_lp'(watchdog_cycles_p));
  assign wd_trip = wd_inc & (wd == wd_width_lp'(watchdog_cycles_p - 1));

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)    wd <= '0;
    else if (!wd_inc)  wd <= '0;
    else if (!wd_hit)  wd <= wd + 1'b1;
  end

  logic [err_width_lp-1:0] err;
  logic [err_width_lp-1:0] err_set;

  always_comb begin
    err_set = '0;
    err_set[err_cord_bit_lp] = hdr_hs & (hdr_cord != expected_cord_i);
    err_set[err_cid_bit_lp]  = hdr_hs & (32'(hdr_cid) >= num_cid_p);
    err_set[err_wd_bit_lp]   = wd_trip;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) err <= '0;
    else            err <= err | err_set;
  end

  assign err_code_o = err;
  assign error_o    = |err;

  logic [31:0] flit_cnt;
  logic [31:0] pkt_cnt;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)            flit_cnt <= '0;
    else if (hs & ~&flit_cnt)  flit_cnt <= flit_cnt + 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)                pkt_cnt <= '0;
    else if (pkt_done & ~&pkt_cnt) pkt_cnt <= pkt_cnt + 1'b1;
  end

  assign flit_count_o   = flit_cnt;
  assign packet_count_o = pkt_cnt;

endmodule
